pipelined_write_rx: RTL
=======================

# pipelined_write_rx

Receive-side engine for the pipelined write protocol. It accepts a command cycle on the link, then 1..MAX_WR_CYCLES data beats, and assembles them into one wide word presented on a valid/ready output port. It raises write-done pulses according to the write type and flags protocol and overflow errors. It sits between the link deserialiser and the destination write port, and generalises the fixed 4 x 8-bit pipelined write to arbitrary beat width and depth.

## Interface
- `WR_WIDTH`, 8, width of one data beat.
- `MAX_WR_CYCLES`, 4, maximum beats per write. Must be a power of two, at least 2.
- `CNT_W`, $clog2(MAX_WR_CYCLES), derived width of the num_cycles field. Not overridable.
- `clk` in 1: the only clock. All logic is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_cmd_val` in 1: command cycle valid.
- `in_num_cycles` in CNT_W: beat count. 0 encodes MAX_WR_CYCLES.
- `in_write_type` in 2: 0=STD, 1=MULTI_WDONE, 2=SINGLE_WDONE, 3=reserved.
- `in_cycle_type` in 2: data-cycle type, 0=IDLE, 1=VALID, 2=DONE, 3=reserved.
- `in_dat` in WR_WIDTH: beat payload.
- `out_val` out 1: assembled write available.
- `out_rdy` in 1: downstream accepts.
- `out_dat` out MAX_WR_CYCLES*WR_WIDTH: beat k occupies bits [k*WR_WIDTH +: WR_WIDTH]. Unused beats are zero.
- `out_num_cycles` out CNT_W: the command's num_cycles field, passed through unchanged.
- `out_write_type` out 2: write type of the held write.
- `wdone` out 1: write-done pulse.
- `err_proto` out 1: one-cycle protocol-error pulse.
- `err_ovf` out 1: one-cycle overflow pulse. Signals a completed write that was dropped.

## Operation
- FSM states: IDLE and DATA. A separate output-holding register (`out_val`) operates independently of the FSM.
- IDLE, `in_cmd_val`=1 with a legal type:
  - latch N (num_cycles, with 0 mapped to MAX), type and num_cycles;
  - clear the beat index and the assembly buffer;
  - go to DATA.
- IDLE, `in_cmd_val`=1 with type 3: `err_proto`. The command is discarded and the FSM stays in IDLE.
- IDLE, `in_cycle_type` VALID or DONE with no command: `err_proto`. The beat is ignored.
- DATA, per cycle:
  - IDLE beat: a gap. Nothing happens.
  - VALID beat with index < N-1: store the beat at the index, then index++.
  - DONE beat with index == N-1: store the beat, the write completes, go to IDLE.
  - DONE beat with index < N-1, VALID beat with index == N-1, or a type-3 beat: `err_proto`, the write is aborted, go to IDLE. No `wdone`.
- Command priority:
  - `in_cmd_val`=1 always takes priority over `in_cycle_type`.
  - If the same cycle also has `in_cycle_type`≠IDLE, raise `err_proto` and ignore the data.
  - `in_cmd_val`=1 while in DATA: `err_proto`, the partial write is aborted, and the new command is accepted as in IDLE.
- Completion:
  - If the output register is empty, or is being drained this cycle (`out_val`&`out_rdy`), load the buffer, type and num_cycles, and set `out_val`.
  - Otherwise the write is dropped and `err_ovf` pulses. The held output is unchanged.
- wdone:
  - MULTI: one pulse per stored beat (VALID or DONE).
  - SINGLE: one pulse per completed, non-dropped write.
  - STD: never pulses.
  - A dropped SINGLE write produces no `wdone`. MULTI pulses already issued for it stand.
- The output is cleared when `out_val`&`out_rdy`. It may be reloaded in the same cycle.

## Timing
- Reset values: FSM=IDLE, index=0, buffer=0. `out_val`=0, `out_dat`=0, `out_num_cycles`=0, `out_write_type`=0. `wdone`=0, `err_proto`=0, `err_ovf`=0.
- All outputs are registered.
- Latency:
  - `out_val` rises one cycle after the DONE beat is sampled.
  - MULTI `wdone` follows each beat by one cycle.
  - SINGLE `wdone` coincides with `out_val` rising.
  - Error pulses follow the offending cycle by one cycle.
- Throughput: a new command may arrive in the cycle after DONE. The minimum write is 2 link cycles for N=1.
- The link has no backpressure. Input is always consumed.
- `out_dat` is stable while `out_val`=1 and `out_rdy`=0.
- A reset mid-write returns every state element to its reset value immediately. The partial write is lost and no pulse is issued.

## Test plan
- Default parameters, cmd N=0 (4 beats) with type SINGLE, beats 0x11, 0x22, 0x33 (VALID) and 0x44 (DONE), `out_rdy`=1. Required: `out_dat`=0x44332211, `out_num_cycles`=0, one `wdone` aligned with `out_val`, no errors.
- Cmd N=2 with type MULTI, beats 0xA5 (VALID), IDLE gap, 0x5A (DONE). Required: `out_dat`=0x00005AA5, exactly 2 `wdone` pulses, each one cycle after its beat.
- Cmd N=3, then DONE at index 1. Required: `err_proto`, FSM back to IDLE, `out_val` stays 0, no `wdone`.
- Cmd N=1 with type STD and DONE 0x7E, `out_rdy` held 0. Then a second cmd N=1 with DONE 0x01. Required: `err_ovf` pulses, `out_dat` stays 0x7E, `wdone` never asserts.
- Cmd N=4 with 2 beats, then a new cmd N=1 with type SINGLE and DONE 0xC3. Required: `err_proto` on the interrupting cmd, output 0x000000C3, one `wdone`.
- `WR_WIDTH`=16, `MAX_WR_CYCLES`=8, N=0, beats 0x0001..0x0008. Assert `rst` after beat 5, then run a full write. Required: no output from the interrupted write, all outputs at reset values, and the following write is correct with beat k at [16k +: 16].

Source files
------------

// File: rtl/pipelined_write_rx.sv
// Pipelined-write receiver: command + 1..MAX_WR_CYCLES beats assembled into one wide word.
// All outputs registered, out_val one cycle after DONE; link never stalls, a full output drops the write (err_ovf).
`timescale 1ns/1ps
module pipelined_write_rx #(
  parameter int WR_WIDTH      = 8,
  parameter int MAX_WR_CYCLES = 4,
  localparam int CNT_W        = $clog2(MAX_WR_CYCLES)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_cmd_val,
  input  logic [CNT_W-1:0]                  in_num_cycles,
  input  logic [1:0]                        in_write_type,
  input  logic [1:0]                        in_cycle_type,
  input  logic [WR_WIDTH-1:0]               in_dat,
  output logic                              out_val,
  input  logic                              out_rdy,
  output logic [MAX_WR_CYCLES*WR_WIDTH-1:0] out_dat,
  output logic [CNT_W-1:0]                  out_num_cycles,
  output logic [1:0]                        out_write_type,
  output logic                              wdone,
  output logic                              err_proto,
  output logic                              err_ovf
);

  localparam int DAT_W = MAX_WR_CYCLES * WR_WIDTH;

  localparam logic [1:0] CT_IDLE  = 2'd0;
  localparam logic [1:0] CT_VALID = 2'd1;
  localparam logic [1:0] CT_DONE  = 2'd2;

  localparam logic [1:0] WT_MULTI  = 2'd1;
  localparam logic [1:0] WT_SINGLE = 2'd2;
  localparam logic [1:0] WT_RSV    = 2'd3;

  typedef enum logic {S_IDLE, S_DATA} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   last_q, last_d;
  logic [1:0]         type_q, type_d;
  logic [CNT_W-1:0]   ncyc_q, ncyc_d;
  logic [DAT_W-1:0]   buf_q, buf_d;
  logic [DAT_W-1:0]   buf_wr;

  logic               out_val_q, out_val_d;
  logic [DAT_W-1:0]   out_dat_q, out_dat_d;
  logic [CNT_W-1:0]   out_ncyc_q, out_ncyc_d;
  logic [1:0]         out_type_q, out_type_d;
  logic               wdone_q, wdone_d;
  logic               err_proto_q, err_proto_d;
  logic               err_ovf_q, err_ovf_d;

  logic in_data, at_last, cmd_legal, cmd_err;
  logic beat_store, beat_done, beat_bad, stray_beat;
  logic out_free, load, drop;

  assign in_data    = (state_q == S_DATA);
  assign at_last    = (idx_q == last_q);
  assign cmd_legal  = in_cmd_val && (in_write_type != WT_RSV);
  assign cmd_err    = in_cmd_val && ((in_write_type == WT_RSV) || (in_cycle_type != CT_IDLE) || in_data);
  // The index never passes last_q, so "index < N-1" reduces to !at_last.
  assign beat_store = in_data && !in_cmd_val &&
                      (((in_cycle_type == CT_VALID) && !at_last) ||
                       ((in_cycle_type == CT_DONE) && at_last));
  assign beat_done  = beat_store && (in_cycle_type == CT_DONE);
  assign beat_bad   = in_data && !in_cmd_val && !beat_store && (in_cycle_type != CT_IDLE);
  assign stray_beat = !in_data && !in_cmd_val &&
                      ((in_cycle_type == CT_VALID) || (in_cycle_type == CT_DONE));
  assign out_free   = !out_val_q || out_rdy;
  assign load       = beat_done && out_free;
  assign drop       = beat_done && !out_free;

  always_comb begin
    buf_wr = buf_q;
    buf_wr[idx_q*WR_WIDTH +: WR_WIDTH] = in_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      last_q      <= '0;
      type_q      <= '0;
      ncyc_q      <= '0;
      buf_q       <= '0;
      out_val_q   <= 1'b0;
      out_dat_q   <= '0;
      out_ncyc_q  <= '0;
      out_type_q  <= '0;
      wdone_q     <= 1'b0;
      err_proto_q <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      type_q      <= type_d;
      ncyc_q      <= ncyc_d;
      buf_q       <= buf_d;
      out_val_q   <= out_val_d;
      out_dat_q   <= out_dat_d;
      out_ncyc_q  <= out_ncyc_d;
      out_type_q  <= out_type_d;
      wdone_q     <= wdone_d;
      err_proto_q <= err_proto_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  // A command always wins; an illegal one discards any partial write and parks in IDLE.
  always_comb begin
    state_d = state_q;
    if (in_cmd_val) begin
      state_d = cmd_legal ? S_DATA : S_IDLE;
    end else if (beat_done || beat_bad) begin
      state_d = S_IDLE;
    end
  end

  always_comb begin
    idx_d      = idx_q;
    last_d     = last_q;
    type_d     = type_q;
    ncyc_d     = ncyc_q;
    buf_d      = buf_q;
    out_val_d  = out_val_q;
    out_dat_d  = out_dat_q;
    out_ncyc_d = out_ncyc_q;
    out_type_d = out_type_q;

    if (cmd_legal) begin
      idx_d  = '0;
      buf_d  = '0;
      // num_cycles==0 means MAX, and MAX-1 is exactly 0-1 modulo 2**CNT_W.
      last_d = in_num_cycles - 1'b1;
      type_d = in_write_type;
      ncyc_d = in_num_cycles;
    end else if (beat_store) begin
      buf_d = buf_wr;
      if (!beat_done) begin
        idx_d = idx_q + 1'b1;
      end
    end

    if (out_val_q && out_rdy) begin
      out_val_d = 1'b0;
    end
    if (load) begin
      out_val_d  = 1'b1;
      out_dat_d  = buf_wr;
      out_ncyc_d = ncyc_q;
      out_type_d = type_q;
    end

    wdone_d     = (beat_store && (type_q == WT_MULTI)) || (load && (type_q == WT_SINGLE));
    err_proto_d = cmd_err || stray_beat || beat_bad;
    err_ovf_d   = drop;
  end

  assign out_val        = out_val_q;
  assign out_dat        = out_dat_q;
  assign out_num_cycles = out_ncyc_q;
  assign out_write_type = out_type_q;
  assign wdone          = wdone_q;
  assign err_proto      = err_proto_q;
  assign err_ovf        = err_ovf_q;

endmodule
